uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 147 ++++++++++++++
 tb/tb_uart_rx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (start 0, SIZE data LSB first, stop 1).
// Ports:
//   RXC      : in  receive clock, OVS x bit rate
//   R        : in  synchronous active-high reset
//   RXD      : in  asynchronous serial line, idles high
//   RX_ACK   : in  consumer acknowledge, clears RX_VALID/FERR/OVR
//   RXDATA   : out last received word
//   RX_VALID : out RXDATA holds an unacknowledged word
//   RX_BUSY  : out a frame is in progress (state not IDLE)
//   FERR     : out stop bit of the word in RXDATA was sampled 0
//   OVR      : out a word completed while RX_VALID was already set
module uart_rx #(
    parameter int SIZE = 8,
    parameter int OVS  = 16
) (
    input  logic            RXC,
    input  logic            R,
    input  logic            RXD,
    input  logic            RX_ACK,
    output logic [SIZE-1:0] RXDATA,
    output logic            RX_VALID,
    output logic            RX_BUSY,
    output logic            FERR,
    output logic            OVR
);

    localparam int CW = $clog2(OVS);
    localparam int BW = $clog2(SIZE) + 1;

    // The IDLE->START edge already spends one cycle of the half bit,
    // so the start-bit centre is reached when cnt shows OVS/2-2.
    localparam logic [CW-1:0] HALF = CW'(OVS / 2 - 2);
    localparam logic [CW-1:0] LAST = CW'(OVS - 1);
    localparam logic [BW-1:0] TOP  = BW'(SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t          state;
    state_t          state_n;
    logic            sync1;
    logic            rxd_s;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic [BW-1:0]   bidx;
    logic [BW-1:0]   bidx_n;
    logic [SIZE-1:0] sh;
    logic [SIZE-1:0] sh_n;
    logic            done;

    always_ff @(posedge RXC) begin
        if (R) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
            bidx  <= '0;
            sh    <= '0;
        end else begin
            sync1 <= RXD;
            rxd_s <= sync1;
            state <= state_n;
            cnt   <= cnt_n;
            bidx  <= bidx_n;
            sh    <= sh_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bidx_n  = bidx;
        sh_n    = sh;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                cnt_n = cnt + CW'(1);
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    bidx_n  = '0;
                    state_n = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_n = cnt + CW'(1);
                if (cnt == LAST) begin
                    cnt_n  = '0;
                    // MSB-in shift: the first bit ends up in bit 0
                    sh_n   = {rxd_s, sh[SIZE-1:1]};
                    bidx_n = bidx + BW'(1);
                    if (bidx == TOP) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                cnt_n = cnt + CW'(1);
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    done    = 1'b1;
                    state_n = rxd_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rxd_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Completion takes priority over an acknowledge in the same cycle.
    always_ff @(posedge RXC) begin
        if (R) begin
            RXDATA   <= '0;
            RX_VALID <= 1'b0;
            FERR     <= 1'b0;
            OVR      <= 1'b0;
        end else if (done) begin
            RXDATA   <= sh;
            RX_VALID <= 1'b1;
            FERR     <= ~rxd_s;
            OVR      <= OVR | (RX_VALID & ~RX_ACK);
        end else if (RX_ACK && RX_VALID) begin
            RX_VALID <= 1'b0;
            FERR     <= 1'b0;
            OVR      <= 1'b0;
        end
    end

    assign RX_BUSY = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (SIZE=8, OVS=16).
// Directed table, hand-written corner cases and random frames vs a model.
module tb_uart_rx;

    logic       RXC;
    logic       R;
    logic       RXD;
    logic       RX_ACK;
    logic [7:0] RXDATA;
    logic       RX_VALID;
    logic       RX_BUSY;
    logic       FERR;
    logic       OVR;

    int cyc;
    int checks;
    int errors;

    bit         m_valid;
    bit         m_ferr;
    bit         m_ovr;
    logic [7:0] m_data;

    uart_rx #(
        .SIZE(8),
        .OVS (16)
    ) dut (
        .RXC     (RXC),
        .R       (R),
        .RXD     (RXD),
        .RX_ACK  (RX_ACK),
        .RXDATA  (RXDATA),
        .RX_VALID(RX_VALID),
        .RX_BUSY (RX_BUSY),
        .FERR    (FERR),
        .OVR     (OVR)
    );

    initial begin
        RXC = 1'b0;
        forever #5 RXC = ~RXC;
    end

    always @(posedge RXC) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] data;
        bit         stop;
        int         mode;
        int         gap;
        bit         ack_after;
        bit         pre_valid;
        logic [7:0] exp_data;
        bit         exp_ferr;
        bit         exp_ovr;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic ack_now();
        RX_ACK = 1'b1;
        @(negedge RXC);
        RX_ACK = 1'b0;
        check("ack_valid", RX_VALID, 0);
        check("ack_ferr", FERR, 0);
        check("ack_ovr", OVR, 0);
    endtask

    // mode 0: no ack, 1: ack the cycle after completion,
    // 2: ack on the stop-sample edge itself.
    // Stop is sampled at E+153, E = first edge capturing the start bit.
    task automatic send_frame(input logic [7:0] d,
                              input bit stop,
                              input int mode,
                              input bit pre_valid,
                              input logic [7:0] ed,
                              input bit ef,
                              input bit eo);
        int t0;
        t0  = cyc;
        RXD = 1'b0;
        repeat (16) @(negedge RXC);
        for (int i = 0; i < 8; i++) begin
            RXD = d[i];
            repeat (16) @(negedge RXC);
        end
        RXD = stop;
        repeat (9) @(negedge RXC);
        check("busy_pre_stop", RX_BUSY, 1);
        check("valid_pre_stop", RX_VALID, pre_valid);
        if (mode == 2) RX_ACK = 1'b1;
        @(negedge RXC);
        RX_ACK = 1'b0;
        check("rxdata", RXDATA, ed);
        check("valid", RX_VALID, 1);
        check("ferr", FERR, ef);
        check("ovr", OVR, eo);
        check("busy_post_stop", RX_BUSY, !stop);
        if (mode == 1) ack_now();
        while (cyc < t0 + 160) @(negedge RXC);
    endtask

    initial begin
        int bad;
        int busy_cnt;
        int gap;
        int mode;
        bit stop;
        bit eo;
        logic [7:0] d;

        cyc    = 0;
        checks = 0;
        errors = 0;
        R      = 1'b1;
        RXD    = 1'b1;
        RX_ACK = 1'b0;

        tbl[0] = '{8'hA5, 1, 1, 0,  0, 0, 8'hA5, 0, 0};
        tbl[1] = '{8'h3C, 1, 1, 20, 0, 0, 8'h3C, 0, 0};
        tbl[2] = '{8'h11, 1, 0, 0,  0, 0, 8'h11, 0, 0};
        tbl[3] = '{8'h22, 1, 0, 20, 1, 1, 8'h22, 0, 1};
        tbl[4] = '{8'h11, 1, 0, 10, 0, 0, 8'h11, 0, 0};
        tbl[5] = '{8'h7E, 1, 2, 10, 0, 1, 8'h7E, 0, 0};

        repeat (3) @(negedge RXC);
        check("rst_data", RXDATA, 0);
        check("rst_valid", RX_VALID, 0);
        check("rst_busy", RX_BUSY, 0);
        check("rst_ferr", FERR, 0);
        check("rst_ovr", OVR, 0);
        R = 1'b0;

        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge RXC);
            if (RX_BUSY || RX_VALID || FERR || OVR) bad++;
            if (RXDATA != 8'h00) bad++;
        end
        check("idle_quiet", bad, 0);

        // short low glitch: START for 7 cycles, then back to IDLE
        RXD      = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge RXC);
            if (RX_BUSY) busy_cnt++;
            if (i == 3) RXD = 1'b1;
        end
        check("glitch_busy_cycles", busy_cnt, 7);
        check("glitch_busy_end", RX_BUSY, 0);
        check("glitch_valid", RX_VALID, 0);

        // framing error, line held low: one word, BREAK until high
        send_frame(8'h55, 0, 0, 0, 8'h55, 1, 0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge RXC);
            if (!RX_BUSY || !RX_VALID || OVR || !FERR) bad++;
            if (RXDATA != 8'h55) bad++;
        end
        check("break_hold", bad, 0);
        RXD = 1'b1;
        repeat (2) @(negedge RXC);
        check("break_busy_sync", RX_BUSY, 1);
        @(negedge RXC);
        check("break_exit", RX_BUSY, 0);
        check("break_ovr", OVR, 0);
        ack_now();
        repeat (5) @(negedge RXC);

        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].data, tbl[i].stop, tbl[i].mode,
                       tbl[i].pre_valid, tbl[i].exp_data,
                       tbl[i].exp_ferr, tbl[i].exp_ovr);
            RXD = 1'b1;
            repeat (tbl[i].gap) @(negedge RXC);
            if (tbl[i].ack_after) ack_now();
        end

        // reset during data bit 4 with 0x7E still pending
        RXD = 1'b0;
        d   = 8'hF0;
        repeat (16) @(negedge RXC);
        for (int i = 0; i < 4; i++) begin
            RXD = d[i];
            repeat (16) @(negedge RXC);
        end
        RXD = d[4];
        repeat (8) @(negedge RXC);
        R = 1'b1;
        @(negedge RXC);
        R = 1'b0;
        check("midrst_data", RXDATA, 0);
        check("midrst_valid", RX_VALID, 0);
        check("midrst_busy", RX_BUSY, 0);
        check("midrst_ferr", FERR, 0);
        check("midrst_ovr", OVR, 0);
        RXD = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge RXC);
            if (RX_VALID || RX_BUSY) bad++;
        end
        check("midrst_no_word", bad, 0);

        m_valid = 0;
        m_ferr  = 0;
        m_ovr   = 0;
        m_data  = 8'h00;
        for (int i = 0; i < 24; i++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            mode = $urandom_range(0, 2);
            eo   = m_ovr | (m_valid & (mode != 2));
            send_frame(d, stop, mode, m_valid, d, !stop, eo);
            m_data  = d;
            m_valid = 1;
            m_ferr  = !stop;
            m_ovr   = eo;
            if (mode == 1) begin
                m_valid = 0;
                m_ferr  = 0;
                m_ovr   = 0;
            end
            gap = stop ? $urandom_range(0, 12) : $urandom_range(4, 12);
            RXD = 1'b1;
            repeat (gap) @(negedge RXC);
        end
        repeat (4) @(negedge RXC);
        check("rand_end_valid", RX_VALID, m_valid);
        check("rand_end_data", RXDATA, m_data);
        check("rand_end_ferr", FERR, m_ferr);
        check("rand_end_ovr", OVR, m_ovr);
        check("rand_end_busy", RX_BUSY, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
